// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-side SRAM responder.
// FSM encodings, lane indices, default window base and the request bundle.
package data_sram_resp_pkg;

  localparam logic [0:0] DSRAM_IDLE = 1'b0;
  localparam logic [0:0] DSRAM_WAIT = 1'b1;

  localparam int LANE0 = 0;
  localparam int LANE1 = 1;
  localparam int LANE2 = 2;
  localparam int LANE3 = 3;
  localparam int NLANE = 4;

  localparam logic [31:0] DSRAM_BASE_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dsram_req_t;

endpackage

// File: rtl/data_sram_resp_bank.sv
// Byte-writable synchronous word array with a registered read port.
// The array itself is not reset; only the read register is.
module dsram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [NLANE-1:0][7:0] mem [DEPTH];
  logic [31:0]           rdata_q;

  // Per-lane write; lanes with a clear enable keep their contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (we[i]) begin
        mem[idx][i] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register: loads on a read, clears on a miss, otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[idx];
    end else if (clr) begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: window decode, byte writes, 1-cycle read data.
// Define DSRAM_WAIT_EN to build the wait-state FSM and stall output.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE_ADDR   = DSRAM_BASE_DEFAULT,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ram_en,
  input  logic [3:0]  data_ram_wen,
  input  logic [31:0] data_ram_addr,
  input  logic [31:0] data_ram_wdata,
  output logic [31:0] data_ram_rdata,
  output logic        data_ram_stall,
  output logic        data_ram_addr_err
);

  dsram_req_t req_in;
  dsram_req_t acc;
  logic       fire;
  logic       fire_ok;
  logic       hit;
  logic       addr_err_q;
  logic       addr_err_d;
  logic [3:0] bank_we;
  logic       bank_re;
  logic       bank_clr;
  logic       unused_addr_lsb;

  assign req_in = '{wen:   data_ram_wen,
                    addr:  data_ram_addr,
                    wdata: data_ram_wdata};

`ifdef DSRAM_WAIT_EN
  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  dsram_req_t    lat_q;
  dsram_req_t    lat_d;
  logic          stall_c;

  // Wait-state sequencing: latch the request, count down, then fire it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    stall_c = 1'b0;
    fire    = 1'b0;
    acc     = req_in;
    if (state_q == DSRAM_IDLE) begin
      if (data_ram_en) begin
        if (WAIT_CYCLES == 0) begin
          fire = 1'b1;
        end else begin
          stall_c = 1'b1;
          lat_d   = req_in;
          cnt_d   = CW'(WAIT_CYCLES - 1);
          state_d = DSRAM_WAIT;
        end
      end
    end else begin
      stall_c = 1'b1;
      acc     = lat_q;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        fire    = 1'b1;
        state_d = DSRAM_IDLE;
      end
    end
  end

  // FSM, counter and request latch; reset aborts any pending access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DSRAM_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  assign data_ram_stall = stall_c & ~rst;
`else
  assign fire           = data_ram_en;
  assign acc            = req_in;
  assign data_ram_stall = 1'b0;
`endif

  assign fire_ok = fire & ~rst;
  assign hit     = (acc.addr[31:AW+2] == BASE_ADDR[31:AW+2]);

  assign unused_addr_lsb = ^acc.addr[1:0];

  // Steer the access into the bank: hits write or read, misses clear rdata
  always_comb begin
    bank_we    = 4'b0000;
    bank_re    = 1'b0;
    bank_clr   = 1'b0;
    addr_err_d = 1'b0;
    if (fire_ok) begin
      if (hit) begin
        bank_we = acc.wen;
        bank_re = (acc.wen == 4'b0000);
      end else begin
        bank_clr   = 1'b1;
        addr_err_d = 1'b1;
      end
    end
  end

  // Error pulse aligned with the read data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  dsram_bank #(
    .AW(AW)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (bank_we),
    .re   (bank_re),
    .clr  (bank_clr),
    .idx  (acc.addr[AW+1:2]),
    .wdata(acc.wdata),
    .rdata(data_ram_rdata)
  );

  assign data_ram_addr_err = addr_err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp.
// Wait-state scenarios run only when DSRAM_WAIT_EN is defined.
module tb_data_sram_resp;

  localparam int AW = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int WC = 2;
`ifdef DSRAM_WAIT_EN
  localparam int EXP_STALL = (WC > 0) ? WC + 1 : 0;
`else
  localparam int EXP_STALL = 0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        addr_err;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [31:0] mdl [1 << AW];
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  data_sram_resp #(
    .AW(AW),
    .BASE_ADDR(BASE),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_ram_en(en),
    .data_ram_wen(wen),
    .data_ram_addr(addr),
    .data_ram_wdata(wdata),
    .data_ram_rdata(rdata),
    .data_ram_stall(stall),
    .data_ram_addr_err(addr_err)
  );

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_hit(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return a[31:AW+2] == b[31:AW+2];
  endfunction

  // Model the access and push what the DUT must show afterwards
  task automatic model_push(input logic [3:0] w,
                            input logic [31:0] a,
                            input logic [31:0] d);
    exp_t e;
    int   i;
    i = int'(a[AW+1:2]);
    e.err = 1'b0;
    if (!is_hit(a)) begin
      last_rd = '0;
      e.err = 1'b1;
    end else if (w == 4'h0) begin
      last_rd = mdl[i];
    end else begin
      for (int l = 0; l < 4; l++)
        if (w[l]) mdl[i][8*l +: 8] = d[8*l +: 8];
    end
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  task automatic access(input string tag,
                        input logic [3:0] w,
                        input logic [31:0] a,
                        input logic [31:0] d);
    int   stalls;
    exp_t e;
    @(negedge clk);
    en = 1'b1;
    wen = w;
    addr = a;
    wdata = d;
    model_push(w, a, d);
    #1;
    stalls = 0;
    while (stall && stalls < 20) begin
      stalls++;
      @(negedge clk);
      en = 1'b0;
      wen = ~w;
      addr = a ^ 32'h0000_0004;
      wdata = ~d;
      #1;
    end
    if (stalls == 0) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_stall"}, stalls, EXP_STALL);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_rdata"}, rdata, e.rdata);
      check_eq({tag, "_err"}, addr_err, e.err);
    end
    en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  rw;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_stall", stall, 32'h0);
    check_eq("rst_err", addr_err, 32'h0);

    access("w0", 4'hF, BASE, 32'h0);
    access("r0", 4'h0, BASE, 32'h0);
    access("w10", 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
    access("r10", 4'h0, BASE + 32'h10, 32'h0);
    access("wb2", 4'b0100, BASE + 32'h10, 32'h00AA_0000);
    access("r10b", 4'h0, BASE + 32'h10, 32'h0);

    access("miss_r", 4'h0, BASE + (32'd4 << AW), 32'h0);
    access("after_miss", 4'h0, BASE, 32'h0);
    access("miss_w", 4'hF, BASE + (32'd4 << AW) + 32'h10, 32'hFFFF_FFFF);
    access("r10c", 4'h0, BASE + 32'h10, 32'h0);

    for (int k = 0; k < 8; k++)
      access("init", 4'hF, BASE + 32'(k * 4), 32'hA500_0000 | 32'(k));
    for (int k = 0; k < 24; k++) begin
      r = $urandom;
      rw = (k % 3 == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      access("rand", rw, BASE + 32'($urandom_range(0, 7) * 4), r);
    end

`ifdef DSRAM_WAIT_EN
    if (WC > 0) begin
      @(negedge clk);
      en = 1'b1;
      wen = 4'hF;
      addr = BASE + 32'h10;
      wdata = 32'h1234_5678;
      @(negedge clk);
      en = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("rstwait_stall", stall, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      last_rd = '0;
      #1;
      check_eq("rstwait_rdata", rdata, 32'h0);
      access("rstwait_rd", 4'h0, BASE + 32'h10, 32'h0);
    end
`endif

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
